// File: rtl/stack_controller_if.sv
// rtl/stack_controller_if.sv - control/status bundle between stack_controller and the stack-machine datapath
//
// Purpose: groups the decoded-instruction inputs and every datapath control
// strobe so the controller and datapath connect through one port.
// Signals:
//   opcode[2:0]   IR[7:5] from the datapath
//   alu_zero      ALU result == 0
//   pc_src        0: PC <= ALU_out[4:0]; 1: PC <= IR[4:0]
//   pc_write      unconditional PC load
//   pc_write_con  PC load qualified by z
//   z             alu_zero while evaluating JZ, else 0
//   mem_sel       0: mem addr = PC; 1: mem addr = IR[4:0]
//   mem_read      memory read enable
//   mem_write     memory write enable (data = register A)
//   ir_write      IR load
//   stack_sel     0: stack in = RRES; 1: stack in = MDR
//   load_a        A <= stack d_out
//   a_sel         0: ALU A = PC; 1: ALU A = reg A
//   b_sel         0: ALU B = 1; 1: ALU B = reg B
//   push/pop/tos  stack commands
//   alu_op[2:0]   ALU operation
//   instr_done    pulse in the last cycle of each instruction
// Modports: master = controller side, slave = datapath side.
interface stack_controller_if;
   logic [2:0] opcode;
   logic       alu_zero;
   logic       pc_src;
   logic       pc_write;
   logic       pc_write_con;
   logic       z;
   logic       mem_sel;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       stack_sel;
   logic       load_a;
   logic       a_sel;
   logic       b_sel;
   logic       push;
   logic       pop;
   logic       tos;
   logic [2:0] alu_op;
   logic       instr_done;

   modport master (
      input  opcode, alu_zero,
      output pc_src, pc_write, pc_write_con, z, mem_sel, mem_read, mem_write,
             ir_write, stack_sel, load_a, a_sel, b_sel, push, pop, tos,
             alu_op, instr_done
   );

   modport slave (
      output opcode, alu_zero,
      input  pc_src, pc_write, pc_write_con, z, mem_sel, mem_read, mem_write,
             ir_write, stack_sel, load_a, a_sel, b_sel, push, pop, tos,
             alu_op, instr_done
   );
endinterface

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - multi-cycle Moore FSM sequencing the 8-bit stack-machine datapath
//
// Purpose: fetches the instruction at PC, decodes opcode = IR[7:5] and drives
// every datapath strobe one state at a time.
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_n_i   asynchronous active-low reset; forces every strobe to 0 while low
//   ctrl      stack_controller_if.master (opcode/alu_zero in, strobes out)
module stack_controller (
   input  logic                clk_i,
   input  logic                rst_n_i,
   stack_controller_if.master  ctrl
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;
   localparam logic [2:0] OP_PUSH = 3'b100;
   localparam logic [2:0] OP_POP  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_JZ   = 3'b111;

   localparam logic [2:0] ALU_PASS_A = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_POP1     = 4'd2,
      S_POP2     = 4'd3,
      S_LDA      = 4'd4,
      S_BWAIT    = 4'd5,
      S_EXEC     = 4'd6,
      S_WRITE    = 4'd7,
      S_MEM_RD   = 4'd8,
      S_PUSH_MEM = 4'd9,
      S_MEM_WR   = 4'd10,
      S_JUMP     = 4'd11,
      S_TOS      = 4'd12,
      S_JZ_EVAL  = 4'd13
   } state_e;

   typedef struct packed {
      logic       pc_src;
      logic       pc_write;
      logic       pc_write_con;
      logic       z;
      logic       mem_sel;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       stack_sel;
      logic       load_a;
      logic       a_sel;
      logic       b_sel;
      logic       push;
      logic       pop;
      logic       tos;
      logic [2:0] alu_op;
      logic       instr_done;
   } strobe_t;

   state_e  state_q, state_d;
   strobe_t strb;
   strobe_t strb_gated;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = S_FETCH;
      strb    = '0;
      case (state_q)
         S_FETCH: begin
            // PC <= PC + 1 through the ALU (A=PC, B=1, ADD) while IR loads
            strb.mem_read = 1'b1;
            strb.ir_write = 1'b1;
            strb.pc_write = 1'b1;
            state_d       = S_DECODE;
         end
         S_DECODE: begin
            case (ctrl.opcode)
               OP_PUSH: state_d = S_MEM_RD;
               OP_JMP:  state_d = S_JUMP;
               OP_JZ:   state_d = S_TOS;
               default: state_d = S_POP1;
            endcase
         end
         S_POP1: begin
            strb.pop = 1'b1;
            if (ctrl.opcode == OP_ADD || ctrl.opcode == OP_SUB || ctrl.opcode == OP_AND) begin
               state_d = S_POP2;
            end else begin
               state_d = S_LDA;
            end
         end
         S_POP2: begin
            strb.pop    = 1'b1;
            strb.load_a = 1'b1;
            state_d     = S_BWAIT;
         end
         S_LDA: begin
            strb.load_a = 1'b1;
            case (ctrl.opcode)
               OP_NOT:  state_d = S_EXEC;
               OP_POP:  state_d = S_MEM_WR;
               OP_JZ:   state_d = S_JZ_EVAL;
               default: state_d = S_FETCH;
            endcase
         end
         // B register picks up the second popped operand at the end of this cycle
         S_BWAIT: state_d = S_EXEC;
         S_EXEC: begin
            strb.a_sel  = 1'b1;
            strb.b_sel  = 1'b1;
            strb.alu_op = ctrl.opcode;
            state_d     = S_WRITE;
         end
         S_WRITE: begin
            strb.push       = 1'b1;
            strb.instr_done = 1'b1;
            state_d         = S_FETCH;
         end
         S_MEM_RD: begin
            strb.mem_sel  = 1'b1;
            strb.mem_read = 1'b1;
            state_d       = S_PUSH_MEM;
         end
         S_PUSH_MEM: begin
            strb.stack_sel  = 1'b1;
            strb.push       = 1'b1;
            strb.instr_done = 1'b1;
            state_d         = S_FETCH;
         end
         S_MEM_WR: begin
            strb.mem_sel    = 1'b1;
            strb.mem_write  = 1'b1;
            strb.instr_done = 1'b1;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            strb.pc_src     = 1'b1;
            strb.pc_write   = 1'b1;
            strb.instr_done = 1'b1;
            state_d         = S_FETCH;
         end
         // JZ peeks the top of stack without popping it
         S_TOS: begin
            strb.tos = 1'b1;
            state_d  = S_LDA;
         end
         S_JZ_EVAL: begin
            strb.a_sel        = 1'b1;
            strb.alu_op       = ALU_PASS_A;
            strb.pc_src       = 1'b1;
            strb.pc_write_con = 1'b1;
            strb.z            = ctrl.alu_zero;
            strb.instr_done   = 1'b1;
            state_d           = S_FETCH;
         end
         default: begin
            strb    = '0;
            state_d = S_FETCH;
         end
      endcase
   end

   // Outputs drop to zero as soon as reset is asserted, not at the next edge
   assign strb_gated = rst_n_i ? strb : '0;

   assign ctrl.pc_src       = strb_gated.pc_src;
   assign ctrl.pc_write     = strb_gated.pc_write;
   assign ctrl.pc_write_con = strb_gated.pc_write_con;
   assign ctrl.z            = strb_gated.z;
   assign ctrl.mem_sel      = strb_gated.mem_sel;
   assign ctrl.mem_read     = strb_gated.mem_read;
   assign ctrl.mem_write    = strb_gated.mem_write;
   assign ctrl.ir_write     = strb_gated.ir_write;
   assign ctrl.stack_sel    = strb_gated.stack_sel;
   assign ctrl.load_a       = strb_gated.load_a;
   assign ctrl.a_sel        = strb_gated.a_sel;
   assign ctrl.b_sel        = strb_gated.b_sel;
   assign ctrl.push         = strb_gated.push;
   assign ctrl.pop          = strb_gated.pop;
   assign ctrl.tos          = strb_gated.tos;
   assign ctrl.alu_op       = strb_gated.alu_op;
   assign ctrl.instr_done   = strb_gated.instr_done;

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - self-checking bench for stack_controller with a small datapath model
module tb_stack_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stack_controller_if sif ();

   stack_controller dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .ctrl    (sif)
   );

   // ---------------- stimulus source select ----------------
   logic       dp_en;
   logic [2:0] tb_op;
   logic       tb_az;

   // ---------------- datapath model ----------------
   logic [7:0] mem [32];
   logic [7:0] st  [32];
   logic [4:0] pc_q, sp_q;
   logic [7:0] ir_q, mdr_q, a_q, b_q, rres_q, dout_q;
   logic       ld_en;
   logic [4:0] ld_addr;
   logic [7:0] ld_data;
   logic [4:0] maddr;
   logic [7:0] alu_a, alu_b, alu_out;

   assign maddr        = sif.mem_sel ? ir_q[4:0] : pc_q;
   assign sif.opcode   = dp_en ? ir_q[7:5] : tb_op;
   assign sif.alu_zero = dp_en ? (alu_out == 8'd0) : tb_az;

   always_comb begin
      alu_a = sif.a_sel ? a_q : {3'b000, pc_q};
      alu_b = sif.b_sel ? b_q : 8'd1;
      case (sif.alu_op)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_b - alu_a;
         3'b010:  alu_out = alu_a & alu_b;
         3'b011:  alu_out = ~alu_a;
         3'b111:  alu_out = alu_a;
         default: alu_out = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (dp_en && sif.mem_write) mem[ir_q[4:0]] <= a_q;
   end

   always_ff @(posedge clk) begin
      if (dp_en && sif.push) st[sp_q] <= sif.stack_sel ? mdr_q : rres_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= '0; sp_q <= '0; ir_q <= '0; mdr_q <= '0;
         a_q <= '0; b_q <= '0; rres_q <= '0; dout_q <= '0;
      end else if (dp_en) begin
         if (sif.ir_write) ir_q <= mem[maddr];
         if (sif.mem_read) mdr_q <= mem[maddr];
         if (sif.pc_write || (sif.pc_write_con && sif.z))
            pc_q <= sif.pc_src ? ir_q[4:0] : alu_out[4:0];
         if (sif.load_a) a_q <= dout_q;
         b_q    <= dout_q;
         rres_q <= alu_out;
         if (sif.pop) begin
            dout_q <= st[sp_q - 5'd1];
            sp_q   <= sp_q - 5'd1;
         end
         if (sif.tos) dout_q <= st[sp_q - 5'd1];
         if (sif.push) sp_q <= sp_q + 5'd1;
      end
   end

   // ---------------- observation ----------------
   logic [18:0] obs;
   assign obs = {sif.pc_src, sif.pc_write, sif.pc_write_con, sif.z, sif.mem_sel,
                 sif.mem_read, sif.mem_write, sif.ir_write, sif.stack_sel, sif.load_a,
                 sif.a_sel, sif.b_sel, sif.push, sif.pop, sif.tos, sif.alu_op,
                 sif.instr_done};

   localparam logic [18:0] B_PCSRC = 19'h1 << 18;
   localparam logic [18:0] B_PCW   = 19'h1 << 17;
   localparam logic [18:0] B_PCWC  = 19'h1 << 16;
   localparam logic [18:0] B_Z     = 19'h1 << 15;
   localparam logic [18:0] B_MSEL  = 19'h1 << 14;
   localparam logic [18:0] B_MRD   = 19'h1 << 13;
   localparam logic [18:0] B_MWR   = 19'h1 << 12;
   localparam logic [18:0] B_IRW   = 19'h1 << 11;
   localparam logic [18:0] B_SSEL  = 19'h1 << 10;
   localparam logic [18:0] B_LDA   = 19'h1 << 9;
   localparam logic [18:0] B_ASEL  = 19'h1 << 8;
   localparam logic [18:0] B_BSEL  = 19'h1 << 7;
   localparam logic [18:0] B_PUSH  = 19'h1 << 6;
   localparam logic [18:0] B_POP   = 19'h1 << 5;
   localparam logic [18:0] B_TOS   = 19'h1 << 4;
   localparam logic [18:0] B_DONE  = 19'h1;

   localparam logic [18:0] E_ZERO  = 19'h0;
   localparam logic [18:0] E_FETCH = B_MRD | B_IRW | B_PCW;
   localparam logic [18:0] E_POP1  = B_POP;
   localparam logic [18:0] E_POP2  = B_POP | B_LDA;
   localparam logic [18:0] E_LDA   = B_LDA;
   localparam logic [18:0] E_WRITE = B_PUSH | B_DONE;
   localparam logic [18:0] E_MEMRD = B_MSEL | B_MRD;
   localparam logic [18:0] E_PUSHM = B_SSEL | B_PUSH | B_DONE;
   localparam logic [18:0] E_MEMWR = B_MSEL | B_MWR | B_DONE;
   localparam logic [18:0] E_JUMP  = B_PCSRC | B_PCW | B_DONE;
   localparam logic [18:0] E_TOS   = B_TOS;
   localparam logic [18:0] E_JZ0   = B_ASEL | (19'd7 << 1) | B_PCSRC | B_PCWC | B_DONE;
   localparam logic [18:0] E_JZ1   = E_JZ0 | B_Z;

   function automatic logic [18:0] e_exec(input logic [2:0] op);
      return B_ASEL | B_BSEL | ({16'd0, op} << 1);
   endfunction

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int inv_bad = 0;

   always @(negedge clk) begin
      if ((sif.mem_read && sif.mem_write) ||
          (int'(sif.push) + int'(sif.pop) + int'(sif.tos) > 1))
         inv_bad++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        r;
      logic [2:0]  op;
      logic        az;
      logic [18:0] exp;
      string       nm;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [2:0] op, input logic az,
                               input logic [18:0] e, input string nm);
      vec_t v;
      v.r = r; v.op = op; v.az = az; v.exp = e; v.nm = nm;
      vecs.push_back(v);
   endfunction

   task automatic load(input logic [4:0] a, input logic [7:0] d);
      ld_addr = a; ld_data = d; ld_en = 1'b1;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic run_instr(input string nm, input int exp_lat, output logic zs);
      int lat;
      lat = 0;
      zs  = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (sif.z) zs = 1'b1;
         if (sif.instr_done) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      chk({nm, "_latency"}, lat, exp_lat);
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, {31'd0, sif.instr_done}, 32'd0);
   endtask

   function automatic logic [7:0] top_of_stack();
      logic [4:0] ix;
      ix = sp_q - 5'd1;
      return st[ix];
   endfunction

   logic zs;

   initial begin
      rst_n = 1'b0; dp_en = 1'b0; tb_op = 3'b100; tb_az = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;

      // reset held with PUSH opcode, then PUSH, ADD, JMP, JZ both ways, NOT, POP, AND, SUB
      add(0, 3'b100, 0, E_ZERO,  "rst_c1");
      add(0, 3'b100, 0, E_ZERO,  "rst_c2");
      add(0, 3'b100, 0, E_ZERO,  "rst_c3");
      add(1, 3'b100, 0, E_FETCH, "push_fetch");
      add(1, 3'b100, 0, E_ZERO,  "push_decode");
      add(1, 3'b100, 0, E_MEMRD, "push_memrd");
      add(1, 3'b100, 0, E_PUSHM, "push_pushmem");
      add(1, 3'b000, 1, E_FETCH, "add_fetch");
      add(1, 3'b000, 1, E_ZERO,  "add_decode");
      add(1, 3'b000, 1, E_POP1,  "add_pop1");
      add(1, 3'b000, 1, E_POP2,  "add_pop2");
      add(1, 3'b000, 1, E_ZERO,  "add_bwait");
      add(1, 3'b000, 1, e_exec(3'b000), "add_exec");
      add(1, 3'b000, 1, E_WRITE, "add_write");
      add(1, 3'b110, 1, E_FETCH, "jmp_fetch");
      add(1, 3'b110, 1, E_ZERO,  "jmp_decode");
      add(1, 3'b110, 1, E_JUMP,  "jmp_jump");
      add(1, 3'b111, 1, E_FETCH, "jzt_fetch");
      add(1, 3'b111, 1, E_ZERO,  "jzt_decode");
      add(1, 3'b111, 1, E_TOS,   "jzt_tos");
      add(1, 3'b111, 1, E_LDA,   "jzt_lda");
      add(1, 3'b111, 1, E_JZ1,   "jzt_eval");
      add(1, 3'b111, 0, E_FETCH, "jzn_fetch");
      add(1, 3'b111, 0, E_ZERO,  "jzn_decode");
      add(1, 3'b111, 0, E_TOS,   "jzn_tos");
      add(1, 3'b111, 0, E_LDA,   "jzn_lda");
      add(1, 3'b111, 0, E_JZ0,   "jzn_eval");
      add(1, 3'b011, 0, E_FETCH, "not_fetch");
      add(1, 3'b011, 0, E_ZERO,  "not_decode");
      add(1, 3'b011, 0, E_POP1,  "not_pop1");
      add(1, 3'b011, 0, E_LDA,   "not_lda");
      add(1, 3'b011, 0, e_exec(3'b011), "not_exec");
      add(1, 3'b011, 0, E_WRITE, "not_write");
      add(1, 3'b101, 0, E_FETCH, "pop_fetch");
      add(1, 3'b101, 0, E_ZERO,  "pop_decode");
      add(1, 3'b101, 0, E_POP1,  "pop_pop1");
      add(1, 3'b101, 0, E_LDA,   "pop_lda");
      add(1, 3'b101, 0, E_MEMWR, "pop_memwr");
      add(1, 3'b010, 0, E_FETCH, "and_fetch");
      add(1, 3'b010, 0, E_ZERO,  "and_decode");
      add(1, 3'b010, 0, E_POP1,  "and_pop1");
      add(1, 3'b010, 0, E_POP2,  "and_pop2");
      add(1, 3'b010, 0, E_ZERO,  "and_bwait");
      add(1, 3'b010, 0, e_exec(3'b010), "and_exec");
      add(1, 3'b010, 0, E_WRITE, "and_write");
      add(1, 3'b001, 0, E_FETCH, "sub_fetch");

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         rst_n = vecs[i].r; tb_op = vecs[i].op; tb_az = vecs[i].az;
         @(negedge clk);
         chk(vecs[i].nm, {13'd0, obs}, {13'd0, vecs[i].exp});
         @(posedge clk); #1;
      end

      // SUB up to EXEC, then reset asserted mid-cycle
      tb_op = 3'b001;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("sub_exec", {13'd0, obs}, {13'd0, e_exec(3'b001)});
      #2 rst_n = 1'b0;
      #1 chk("async_rst_zero", {13'd0, obs}, 32'd0);
      @(posedge clk); #1;
      chk("rst_held_zero", {13'd0, obs}, 32'd0);
      rst_n = 1'b1;
      #1 chk("restart_fetch", {13'd0, obs}, {13'd0, E_FETCH});
      @(posedge clk); #1;
      chk("restart_decode", {13'd0, obs}, 32'd0);

      // datapath program 1: PUSH 27, PUSH 28, SUB, POP 30 (operand order second - top)
      @(posedge clk); #1;
      rst_n = 1'b0; dp_en = 1'b1;
      load(5'd0, 8'h9B); load(5'd1, 8'h9C); load(5'd2, 8'h20); load(5'd3, 8'hBE);
      load(5'd27, 8'd9); load(5'd28, 8'd5); load(5'd30, 8'hAA);
      rst_n = 1'b1;
      run_instr("p1_push27", 4, zs);
      chk("p1_sp1", sp_q, 1);
      chk("p1_top9", top_of_stack(), 8'd9);
      run_instr("p1_push28", 4, zs);
      chk("p1_sp2", sp_q, 2);
      run_instr("p1_sub", 7, zs);
      chk("p1_sp_after_sub", sp_q, 1);
      chk("p1_sub_result", top_of_stack(), 8'd4);
      run_instr("p1_pop30", 5, zs);
      chk("p1_mem30", mem[30], 8'd4);
      chk("p1_sp0", sp_q, 0);
      chk("p1_pc", pc_q, 4);

      // datapath program 2: PUSH 27, NOT, PUSH 29, JZ 5, ..., PUSH 26, JZ 20, JMP 17
      rst_n = 1'b0;
      load(5'd0, 8'h9B); load(5'd1, 8'h60); load(5'd2, 8'h9D); load(5'd3, 8'hE5);
      load(5'd4, 8'h00); load(5'd5, 8'h9A); load(5'd6, 8'hF4); load(5'd7, 8'hD1);
      load(5'd27, 8'h0F); load(5'd29, 8'h00); load(5'd26, 8'h03);
      rst_n = 1'b1;
      run_instr("p2_push27", 4, zs);
      run_instr("p2_not", 6, zs);
      chk("p2_not_top", top_of_stack(), 8'hF0);
      chk("p2_not_sp", sp_q, 1);
      run_instr("p2_push29", 4, zs);
      chk("p2_sp2", sp_q, 2);
      run_instr("p2_jz_taken", 5, zs);
      chk("p2_jz_taken_z", {31'd0, zs}, 1);
      chk("p2_jz_taken_pc", pc_q, 5);
      chk("p2_jz_taken_sp", sp_q, 2);
      run_instr("p2_push26", 4, zs);
      run_instr("p2_jz_not", 5, zs);
      chk("p2_jz_not_z", {31'd0, zs}, 0);
      chk("p2_jz_not_pc", pc_q, 7);
      chk("p2_jz_not_sp", sp_q, 3);
      run_instr("p2_jmp17", 3, zs);
      chk("p2_jmp_pc", pc_q, 17);

      chk("invariants", inv_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
